int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/common.sv | 20 ++
 rtl/int_prio_enc.sv | 17 +
 rtl/int_ctrl.sv | 121 ++++++++++++
 tb/tb_int_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared definitions for the interrupt controller: source count, register map
// and the request/service state type.
package common;

  localparam int NUM_IRQ = 8;

  localparam logic [15:0] ADDR_ENABLE   = 16'hC010;
  localparam logic [15:0] ADDR_PENDING  = 16'hC011;
  localparam logic [15:0] ADDR_VEC_BASE = 16'hC012;
  localparam logic [15:0] ADDR_CTRL     = 16'hC013;

  localparam logic [15:0] VEC_BASE_RST  = 16'h0008;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational 8-to-3 priority encoder; lowest set index wins.
module int_prio_enc (
  input  logic [7:0] req_i,
  output logic [2:0] id_o,
  output logic       valid_o
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    id_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) id_o = 3'(i);
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/int_ctrl.sv
// Non-nesting interrupt controller: edge-detected sources, memory-mapped
// registers and an IDLE/REQ/ISR sequencer that hands one vector to the PC.
module int_ctrl #(
  parameter int NUM_IRQ = common::NUM_IRQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               stall_IM_ID,
  input  logic               rti_ID_EX,
  input  logic [15:0]        addr,
  input  logic [15:0]        wdata,
  input  logic               we,
  input  logic               re,
  output logic [15:0]        rdata,
  output logic               int_occurred,
  output logic [15:0]        int_vec,
  output logic [1:0]         state_o
);
  import common::*;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_rise;
  logic [NUM_IRQ-1:0] enable_q, enable_d, pending_q, pending_d;
  logic [15:3]        vec_base_q, vec_base_d;
  logic               gie_q, gie_d;
  logic [2:0]         id_q, id_d, enc_id;
  logic               enc_valid, accept, in_isr;
  logic               wr_en, wr_pend, wr_vec, wr_ctrl;

  assign wr_en    = we && (addr == ADDR_ENABLE);
  assign wr_pend  = we && (addr == ADDR_PENDING);
  assign wr_vec   = we && (addr == ADDR_VEC_BASE);
  assign wr_ctrl  = we && (addr == ADDR_CTRL);
  assign irq_rise = irq & ~irq_q;
  assign accept   = (state_q == ST_REQ) && !stall_IM_ID;
  assign state_o  = state_q;

  int_prio_enc u_prio (
    .req_i   (pending_q & enable_q),
    .id_o    (enc_id),
    .valid_o (enc_valid)
  );

  // New edges are OR-ed in last so a set beats a same-cycle clear.
  always_comb begin
    enable_d   = wr_en   ? wdata[NUM_IRQ-1:0] : enable_q;
    vec_base_d = wr_vec  ? wdata[15:3]         : vec_base_q;
    gie_d      = wr_ctrl ? wdata[0]            : gie_q;
    pending_d  = pending_q;
    if (wr_pend) pending_d = pending_d & ~wdata[NUM_IRQ-1:0];
    if (accept)  pending_d[id_q] = 1'b0;
    pending_d  = pending_d | irq_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q      <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      vec_base_q <= VEC_BASE_RST[15:3];
      gie_q      <= 1'b0;
      id_q       <= 3'd0;
    end else begin
      irq_q      <= irq;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      vec_base_q <= vec_base_d;
      gie_q      <= gie_d;
      id_q       <= id_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The id is captured only on IDLE->REQ and is frozen until the next request.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      ST_IDLE: if (gie_q && enc_valid) begin
        state_d = ST_REQ;
        id_d    = enc_id;
      end
      ST_REQ:  if (!stall_IM_ID) state_d = ST_ISR;
      ST_ISR:  if (rti_ID_EX)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_occurred = 1'b0;
    int_vec      = 16'h0000;
    in_isr       = 1'b0;
    case (state_q)
      ST_REQ: begin
        int_occurred = 1'b1;
        int_vec      = {vec_base_q, id_q};
      end
      ST_ISR:  in_isr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdata = 16'h0000;
    if (re) begin
      case (addr)
        ADDR_ENABLE:   rdata = {{(16-NUM_IRQ){1'b0}}, enable_q};
        ADDR_PENDING:  rdata = {{(16-NUM_IRQ){1'b0}}, pending_q};
        ADDR_VEC_BASE: rdata = {vec_base_q, 3'b000};
        ADDR_CTRL:     rdata = {9'd0, id_q, 2'b00, in_isr, gie_q};
        default:       rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the register file and request/service sequence.
module tb_int_ctrl;

  localparam logic [15:0] A_EN   = 16'hC010;
  localparam logic [15:0] A_PEND = 16'hC011;
  localparam logic [15:0] A_VB   = 16'hC012;
  localparam logic [15:0] A_CTRL = 16'hC013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq = 8'h00;
  logic        stall = 1'b0, rti = 1'b0, we = 1'b0, re = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000;
  logic [15:0] rdata, int_vec;
  logic        int_occurred;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq          (irq),
    .stall_IM_ID  (stall),
    .rti_ID_EX    (rti),
    .addr         (addr),
    .wdata        (wdata),
    .we           (we),
    .re           (re),
    .rdata        (rdata),
    .int_occurred (int_occurred),
    .int_vec      (int_vec),
    .state_o      (state_o)
  );

  // Reference model. m_mode: 0 = waiting, 1 = requesting, 2 = servicing.
  logic [7:0]  m_prev, m_pend, m_en, p_n;
  logic        m_gie;
  logic [15:0] m_vb;
  logic [2:0]  m_id;
  int          m_mode, mode_n;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      A_EN:    return {8'h00, m_en};
      A_PEND:  return {8'h00, m_pend};
      A_VB:    return m_vb;
      A_CTRL:  return {9'd0, m_id, 2'b00, (m_mode == 2), m_gie};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 8'h00; m_pend = 8'h00; m_en = 8'h00; m_gie = 1'b0;
      m_vb = 16'h0008; m_id = 3'd0; m_mode = 0;
    end else begin
      p_n = m_pend;
      if (we && addr == A_PEND) p_n = p_n & ~wdata[7:0];
      if (m_mode == 1 && !stall) p_n[m_id] = 1'b0;
      p_n = p_n | (irq & ~m_prev);
      mode_n = m_mode;
      if (m_mode == 0 && m_gie && (m_pend & m_en) != 8'h00) begin
        mode_n = 1;
        m_id = 3'(lowest(m_pend & m_en));
      end else if (m_mode == 1 && !stall) mode_n = 2;
      else if (m_mode == 2 && rti) mode_n = 0;
      if (we && addr == A_EN)   m_en  = wdata[7:0];
      if (we && addr == A_VB)   m_vb  = wdata & 16'hFFF8;
      if (we && addr == A_CTRL) m_gie = wdata[0];
      m_pend = p_n;
      m_prev = irq;
      m_mode = mode_n;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    next();
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    #1;
    d = rdata;
    re = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq = 8'h00; stall = 1'b0; rti = 1'b0; we = 1'b0; re = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    do_reset();
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL reset_occ: got %b expected 0", int_occurred); end
    rd(A_EN, d);   checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_enable: got %h expected 0000", d); end
    rd(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h expected 0000", d); end
    rd(A_VB, d);   checks++; if (d !== 16'h0008) begin errors++; $display("FAIL reset_vec_base: got %h expected 0008", d); end
    rd(A_CTRL, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h expected 0000", d); end
    addr = A_VB; re = 1'b0; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL read_no_re: got %h expected 0000", rdata); end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    do_reset();
    wr(A_EN, 16'h0004); wr(A_CTRL, 16'h0001); wr(A_VB, 16'h0040);
    irq = 8'h04;
    next();
    irq = 8'h00;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", int_occurred); end
    next();
    checks++; if (int_occurred !== 1'b1) begin errors++; $display("FAIL basic_occ: got %b expected 1", int_occurred); end
    checks++; if (int_vec !== 16'h0042) begin errors++; $display("FAIL basic_vec: got %h expected 0042", int_vec); end
    next();
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL basic_isr_occ: got %b expected 0", int_occurred); end
    rd(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL basic_pend_clr: got %h expected 0000", d); end
    rd(A_CTRL, d); checks++; if (d !== 16'h0023) begin errors++; $display("FAIL basic_ctrl: got %h expected 0023", d); end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    do_reset();
    wr(A_EN, 16'h00FF); wr(A_CTRL, 16'h0001);
    irq = 8'h22;
    next();
    irq = 8'h00;
    next();
    checks++; if (int_vec !== 16'h0009 || int_occurred !== 1'b1) begin errors++; $display("FAIL prio_first: got occ %b vec %h expected 1 0009", int_occurred, int_vec); end
    next();
    rd(A_PEND, d); checks++; if (d !== 16'h0020) begin errors++; $display("FAIL prio_pend: got %h expected 0020", d); end
    rti = 1'b1; #1;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL prio_rti_occ: got %b expected 0", int_occurred); end
    next();
    rti = 1'b0;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL prio_idle_occ: got %b expected 0", int_occurred); end
    next();
    checks++; if (int_vec !== 16'h000D || int_occurred !== 1'b1) begin errors++; $display("FAIL prio_second: got occ %b vec %h expected 1 000D", int_occurred, int_vec); end
  endtask

  task automatic test_stall();
    logic [15:0] d;
    do_reset();
    wr(A_EN, 16'h0001); wr(A_CTRL, 16'h0001);
    stall = 1'b1; irq = 8'h01;
    next();
    irq = 8'h00;
    next();
    for (int i = 0; i < 4; i++) begin
      checks++; if (int_occurred !== 1'b1 || int_vec !== 16'h0008) begin errors++; $display("FAIL stall_hold%0d: got occ %b vec %h expected 1 0008", i, int_occurred, int_vec); end
      next();
    end
    checks++; if (int_occurred !== 1'b1) begin errors++; $display("FAIL stall_still_req: got %b expected 1", int_occurred); end
    stall = 1'b0;
    next();
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b expected 0", int_occurred); end
    rd(A_CTRL, d); checks++; if (d !== 16'h0003) begin errors++; $display("FAIL stall_ctrl: got %h expected 0003", d); end
  endtask

  task automatic test_isr_edge();
    do_reset();
    wr(A_EN, 16'h00FF); wr(A_CTRL, 16'h0001);
    irq = 8'h01;
    next();
    irq = 8'h00;
    next();
    next();
    irq = 8'h08;
    next();
    irq = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL isr_no_nest%0d: got %b expected 0", i, int_occurred); end
      next();
    end
    rti = 1'b1; #1;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL isr_rti_cycle: got %b expected 0", int_occurred); end
    next();
    rti = 1'b0;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL isr_after_rti: got %b expected 0", int_occurred); end
    next();
    checks++; if (int_occurred !== 1'b1 || int_vec !== 16'h000B) begin errors++; $display("FAIL isr_reissue: got occ %b vec %h expected 1 000B", int_occurred, int_vec); end
  endtask

  task automatic test_w1c_set();
    logic [15:0] d;
    do_reset();
    addr = A_PEND; wdata = 16'h0001; we = 1'b1; irq = 8'h01;
    next();
    we = 1'b0;
    rd(A_PEND, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL w1c_set_wins: got %h expected 0001", d); end
    wr(A_PEND, 16'h0001);
    rd(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL w1c_clear: got %h expected 0000", d); end
    irq = 8'h00;
  endtask

  task automatic test_reset_mid_req();
    logic [15:0] d;
    do_reset();
    wr(A_EN, 16'h00FF); wr(A_VB, 16'h0100); wr(A_CTRL, 16'h0001);
    stall = 1'b1; irq = 8'h10;
    next();
    irq = 8'h00;
    next();
    checks++; if (int_occurred !== 1'b1 || int_vec !== 16'h0104) begin errors++; $display("FAIL midreq_pre: got occ %b vec %h expected 1 0104", int_occurred, int_vec); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (int_occurred !== 1'b0) begin errors++; $display("FAIL midreq_async: got %b expected 0", int_occurred); end
    rd(A_EN, d);   checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midreq_enable: got %h expected 0000", d); end
    rd(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midreq_pending: got %h expected 0000", d); end
    rd(A_VB, d);   checks++; if (d !== 16'h0008) begin errors++; $display("FAIL midreq_vec_base: got %h expected 0008", d); end
    rd(A_CTRL, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midreq_ctrl: got %h expected 0000", d); end
    stall = 1'b0;
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] exp_r;
    do_reset();
    wr(A_EN, 16'($urandom));
    wr(A_VB, 16'($urandom));
    wr(A_CTRL, 16'h0001);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ (8'($urandom) & 8'($urandom));
      stall = ($urandom_range(0, 2) == 0);
      rti   = (m_mode != 1) && ($urandom_range(0, 3) == 0);
      we    = ($urandom_range(0, 9) == 0);
      addr  = A_EN + 16'($urandom_range(0, 4));
      wdata = 16'($urandom);
      if (we && addr == A_CTRL) wdata[0] = ($urandom_range(0, 4) != 0);
      re    = ($urandom_range(0, 1) == 1);
      #1;
      exp_r = re ? m_read(addr) : 16'h0000;
      checks++; if (int_occurred !== (m_mode == 1)) begin errors++; $display("FAIL rand_occ@%0d: got %b expected %b", n, int_occurred, (m_mode == 1)); end
      if (m_mode == 1) begin
        checks++; if (int_vec !== {m_vb[15:3], m_id}) begin errors++; $display("FAIL rand_vec@%0d: got %h expected %h", n, int_vec, {m_vb[15:3], m_id}); end
      end
      checks++; if (rdata !== exp_r) begin errors++; $display("FAIL rand_rdata@%0d addr %h: got %h expected %h", n, addr, rdata, exp_r); end
      checks++; if (int_occurred && rti) begin errors++; $display("FAIL rand_occ_rti@%0d: got occ 1 with rti 1 expected occ 0", n); end
      next();
    end
    irq = 8'h00; stall = 1'b0; rti = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_stall();
    test_isr_edge();
    test_w1c_set();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
